// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the divide sequencer and divider
package div_pkg;

   // Sequencer control states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      BUSY   = 3'd2,
      RESULT = 3'd3,
      DRAIN  = 3'd4
   } div_state_t;

   // Bit positions inside the 4-bit divider flag word
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 3;

   // Default watchdog limit in cycles; must exceed worst-case divider latency
   localparam int DIV_TIMEOUT_DEFAULT = 48;

endpackage

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - issue/writeback sequencer around the integer divider (option: DIVSEQ_TIMEOUT_EN)
module div_sequencer
   import div_pkg::*;
#(
   parameter int BW      = 32,
   parameter int TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_op_stb,
   input  logic          i_op_signed,
   input  logic [BW-1:0] i_op_a,
   input  logic [BW-1:0] i_op_b,
   input  logic [4:0]    i_op_reg,
   output logic          o_op_busy,
   input  logic          i_clear,
   output logic          o_div_wr,
   output logic          o_div_signed,
   output logic [BW-1:0] o_div_num,
   output logic [BW-1:0] o_div_den,
   input  logic          i_div_busy,
   input  logic          i_div_valid,
   input  logic          i_div_err,
   input  logic [BW-1:0] i_div_quotient,
   input  logic [3:0]    i_div_flags,
   output logic          o_wb_valid,
   output logic [4:0]    o_wb_reg,
   output logic [BW-1:0] o_wb_data,
   output logic [3:0]    o_wb_flags,
   output logic          o_wb_err,
   input  logic          i_wb_ack
);

   div_state_t    state_q, state_d;
   logic          div_signed_q, div_signed_d;
   logic [BW-1:0] div_num_q, div_num_d;
   logic [BW-1:0] div_den_q, div_den_d;
   logic          wb_valid_q, wb_valid_d;
   logic          wb_err_q, wb_err_d;
   logic [BW-1:0] wb_data_q, wb_data_d;
   logic [3:0]    wb_flags_q, wb_flags_d;
   logic [4:0]    wb_reg_q, wb_reg_d;
   logic          div_wr;

`ifdef DIVSEQ_TIMEOUT_EN
   localparam logic [5:0] TO_LIMIT = 6'(TIMEOUT - 1);
   logic [5:0] cnt_q, cnt_d;
   logic       timeout;
`endif

   // Next-state, start strobe and result-register updates
   always_comb begin
      state_d      = state_q;
      div_signed_d = div_signed_q;
      div_num_d    = div_num_q;
      div_den_d    = div_den_q;
      wb_valid_d   = wb_valid_q;
      wb_err_d     = wb_err_q;
      wb_data_d    = wb_data_q;
      wb_flags_d   = wb_flags_q;
      wb_reg_d     = wb_reg_q;
      div_wr       = 1'b0;
`ifdef DIVSEQ_TIMEOUT_EN
      timeout      = (cnt_q == TO_LIMIT);
`endif

      case (state_q)
         IDLE: begin
            if (i_op_stb && !i_clear) begin
               div_signed_d = i_op_signed;
               div_num_d    = i_op_a;
               div_den_d    = i_op_b;
               wb_reg_d     = i_op_reg;
               if (i_op_b == '0) begin
                  // Divide by zero never reaches the divider
                  wb_valid_d = 1'b1;
                  wb_err_d   = 1'b1;
                  wb_data_d  = '0;
                  wb_flags_d = 4'h0;
                  state_d    = RESULT;
               end else begin
                  state_d = START;
               end
            end
         end
         START: begin
            // Hold the strobe off while the divider is still finishing older work
            if (!i_div_busy) begin
               div_wr  = 1'b1;
               state_d = i_clear ? DRAIN : BUSY;
            end else if (i_clear) begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (i_clear) begin
               state_d = i_div_valid ? IDLE : DRAIN;
            end else if (i_div_valid) begin
               wb_valid_d = 1'b1;
               wb_err_d   = i_div_err;
               wb_data_d  = i_div_quotient;
               wb_flags_d = i_div_flags;
               state_d    = RESULT;
            end
`ifdef DIVSEQ_TIMEOUT_EN
            else if (timeout) begin
               wb_valid_d = 1'b1;
               wb_err_d   = 1'b1;
               wb_data_d  = '0;
               wb_flags_d = 4'h0;
               state_d    = RESULT;
            end
`endif
         end
         RESULT: begin
            if (i_clear || i_wb_ack) begin
               wb_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         DRAIN: begin
            if (i_div_valid) begin
               state_d = IDLE;
            end
`ifdef DIVSEQ_TIMEOUT_EN
            else if (timeout) begin
               state_d = IDLE;
            end
`endif
         end
         default: begin
            state_d    = IDLE;
            wb_valid_d = 1'b0;
         end
      endcase

`ifdef DIVSEQ_TIMEOUT_EN
      // Watchdog restarts on every state change and only runs while waiting on the divider
      cnt_d = 6'd0;
      if ((state_q == BUSY || state_q == DRAIN) && state_d == state_q) begin
         cnt_d = cnt_q + 6'd1;
      end
`endif
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= IDLE;
         div_signed_q <= 1'b0;
         div_num_q    <= '0;
         div_den_q    <= '0;
         wb_valid_q   <= 1'b0;
         wb_err_q     <= 1'b0;
         wb_data_q    <= '0;
         wb_flags_q   <= 4'h0;
         wb_reg_q     <= 5'd0;
      end else begin
         state_q      <= state_d;
         div_signed_q <= div_signed_d;
         div_num_q    <= div_num_d;
         div_den_q    <= div_den_d;
         wb_valid_q   <= wb_valid_d;
         wb_err_q     <= wb_err_d;
         wb_data_q    <= wb_data_d;
         wb_flags_q   <= wb_flags_d;
         wb_reg_q     <= wb_reg_d;
      end
   end

`ifdef DIVSEQ_TIMEOUT_EN
   // Watchdog counter register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_q <= 6'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign o_op_busy    = (state_q != IDLE);
   assign o_div_wr     = div_wr;
   assign o_div_signed = div_signed_q;
   assign o_div_num    = div_num_q;
   assign o_div_den    = div_den_q;
   assign o_wb_valid   = wb_valid_q;
   assign o_wb_reg     = wb_reg_q;
   assign o_wb_data    = wb_data_q;
   assign o_wb_flags   = wb_flags_q;
   assign o_wb_err     = wb_err_q;

`ifdef FORMAL
   logic wr_pending_q;

   // Track an issued divide until its result strobe returns
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_pending_q <= 1'b0;
      end else if (o_div_wr) begin
         wr_pending_q <= 1'b1;
      end else if (i_div_valid) begin
         wr_pending_q <= 1'b0;
      end
   end

   a_no_wr_busy: assert property (@(posedge i_clk) disable iff (i_reset) !(o_div_wr && i_div_busy));
   a_no_wr_after_reset: assert property (@(posedge i_clk) i_reset |=> !o_div_wr);
   a_single_wr: assert property (@(posedge i_clk) disable iff (i_reset) o_div_wr |-> !wr_pending_q);
   a_valid_expected: assert property (@(posedge i_clk) disable iff (i_reset)
      i_div_valid |-> (state_q == BUSY || state_q == DRAIN));
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer (optional DIVSEQ_TIMEOUT_EN cases)
module tb_div_sequencer;
   import div_pkg::*;

   localparam int BW = 32;
`ifdef DIVSEQ_TIMEOUT_EN
   localparam int TO = 10;
`else
   localparam int TO = DIV_TIMEOUT_DEFAULT;
`endif

   logic          clk;
   logic          i_reset;
   logic          i_op_stb, i_op_signed;
   logic [BW-1:0] i_op_a, i_op_b;
   logic [4:0]    i_op_reg;
   logic          o_op_busy;
   logic          i_clear;
   logic          o_div_wr, o_div_signed;
   logic [BW-1:0] o_div_num, o_div_den;
   logic          i_div_busy, i_div_valid, i_div_err;
   logic [BW-1:0] i_div_quotient;
   logic [3:0]    i_div_flags;
   logic          o_wb_valid;
   logic [4:0]    o_wb_reg;
   logic [BW-1:0] o_wb_data;
   logic [3:0]    o_wb_flags;
   logic          o_wb_err;
   logic          i_wb_ack;

   div_sequencer #(.BW(BW), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_op_stb(i_op_stb), .i_op_signed(i_op_signed), .i_op_a(i_op_a), .i_op_b(i_op_b),
      .i_op_reg(i_op_reg), .o_op_busy(o_op_busy), .i_clear(i_clear),
      .o_div_wr(o_div_wr), .o_div_signed(o_div_signed), .o_div_num(o_div_num), .o_div_den(o_div_den),
      .i_div_busy(i_div_busy), .i_div_valid(i_div_valid), .i_div_err(i_div_err),
      .i_div_quotient(i_div_quotient), .i_div_flags(i_div_flags),
      .o_wb_valid(o_wb_valid), .o_wb_reg(o_wb_reg), .o_wb_data(o_wb_data),
      .o_wb_flags(o_wb_flags), .o_wb_err(o_wb_err), .i_wb_ack(i_wb_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Divider model: result strobe lat cycles after busy rises
   int   lat = 3;
   bit   hang = 1'b0;
   int   cnt = 0;
   bit   pend = 1'b0;
   bit   outstanding = 1'b0;
   int   wr_count = 0;
   int   valid_count = 0;
   logic mdl_valid = 1'b0;
   logic inj_valid = 1'b0;
   logic [BW-1:0] m_a, m_b;
   logic          m_s;

   assign i_div_valid = mdl_valid | inj_valid;

   always @(negedge clk) begin
      logic [BW-1:0] q;
      logic          v;
      mdl_valid = 1'b0;
      if (i_reset) begin
         cnt = 0;
         pend = 1'b0;
         outstanding = 1'b0;
         i_div_busy = 1'b0;
      end else begin
         if (i_div_valid) outstanding = 1'b0;
         if (pend) begin
            pend = 1'b0;
            i_div_busy = 1'b1;
         end
         if (cnt > 1) begin
            cnt--;
         end else if (cnt == 1) begin
            cnt = 0;
            i_div_busy = 1'b0;
            if (!hang) begin
               v = 1'b0;
               if (m_s && m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
                  q = m_a;
                  v = 1'b1;
               end else if (m_s) begin
                  q = $signed(m_a) / $signed(m_b);
               end else begin
                  q = m_a / m_b;
               end
               i_div_quotient = q;
               i_div_err = v;
               i_div_flags = 4'h0;
               i_div_flags[FLAG_Z] = (q == '0);
               i_div_flags[FLAG_N] = q[BW-1];
               i_div_flags[FLAG_V] = v;
               mdl_valid = 1'b1;
               valid_count++;
            end
         end
         if (o_div_wr) begin
            check("wr_while_busy", i_div_busy, 0);
            check("wr_without_valid", outstanding, 0);
            outstanding = 1'b1;
            wr_count++;
            m_a = o_div_num;
            m_b = o_div_den;
            m_s = o_div_signed;
            cnt = lat + 1;
            pend = 1'b1;
         end
      end
   end

   typedef struct {
      logic [4:0]    r;
      logic [BW-1:0] d;
      logic [3:0]    f;
      logic          e;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic          s;
      logic [BW-1:0] a;
      logic [BW-1:0] b;
      logic [4:0]    r;
      int            hold;
      logic [BW-1:0] q;
      logic [3:0]    f;
      logic          e;
   } vec_t;
   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (o_op_busy && n < 200) begin
         tick();
         n++;
      end
      check("wait_idle_bound", o_op_busy, 0);
   endtask

   task automatic drive_op(input logic s, input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [4:0] r);
      i_op_stb = 1'b1;
      i_op_signed = s;
      i_op_a = a;
      i_op_b = b;
      i_op_reg = r;
   endtask

   task automatic finish_op(input int hold);
      int n = 0;
      exp_t e;
      while (!o_wb_valid && n < 100) begin
         tick();
         n++;
      end
      check("wb_valid_bound", o_wb_valid, 1);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("wb_hold_valid", o_wb_valid, 1);
         if (sb.size() > 0) check("wb_hold_data", o_wb_data, sb[0].d);
      end
      i_wb_ack = 1'b1;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_empty actual=result required=no_result");
      end else begin
         e = sb.pop_front();
         check("wb_reg", o_wb_reg, e.r);
         check("wb_data", o_wb_data, e.d);
         check("wb_flags", o_wb_flags, e.f);
         check("wb_err", o_wb_err, e.e);
      end
      tick();
      i_wb_ack = 1'b0;
      check("wb_cleared", o_wb_valid, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int w0;
      wait_idle();
      drive_op(v.s, v.a, v.b, v.r);
      sb.push_back('{v.r, v.q, v.f, v.e});
      w0 = wr_count;
      tick();
      i_op_stb = 1'b0;
      if (v.b == '0) begin
         check("zero_wb_valid_n1", o_wb_valid, 1);
         check("zero_no_wr", o_div_wr, 0);
      end else begin
         check("wr_at_n1", o_div_wr, 1);
      end
      finish_op(v.hold);
      check("wr_pulses", wr_count - w0, (v.b == '0) ? 0 : 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int w0, v0, n;
      bit saw_wb;

      vecs[0] = '{1'b0, 32'd100, 32'd7, 5'd3, 3, 32'd14, 4'h0, 1'b0};
      vecs[1] = '{1'b0, 32'd5, 32'd0, 5'd9, 1, 32'd0, 4'h0, 1'b1};
      vecs[2] = '{1'b1, 32'hFFFF_FFEC, 32'd3, 5'd17, 0, 32'hFFFF_FFFA, 4'h2, 1'b0};
      vecs[3] = '{1'b0, 32'd0, 32'd5, 5'd31, 0, 32'd0, 4'h1, 1'b0};
      vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 5'd1, 2, 32'hFFFF_FFFF, 4'h2, 1'b0};
      vecs[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 32'h8000_0000, 4'hA, 1'b1};

      i_reset = 1'b1;
      i_op_stb = 1'b0; i_op_signed = 1'b0; i_op_a = '0; i_op_b = '0; i_op_reg = '0;
      i_clear = 1'b0; i_wb_ack = 1'b0;
      i_div_busy = 1'b0; i_div_err = 1'b0; i_div_quotient = '0; i_div_flags = '0;
      repeat (3) tick();
      i_reset = 1'b0;
      check("rst_busy", o_op_busy, 0);
      check("rst_wb_valid", o_wb_valid, 0);
      check("rst_div_wr", o_div_wr, 0);
      check("rst_wb_err", o_wb_err, 0);
      check("rst_wb_data", o_wb_data, 0);
      check("rst_div_num", o_div_num, 0);
      tick();

      // Table-driven single operations
      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Clear in IDLE blocks a same-cycle op
      wait_idle();
      drive_op(1'b0, 32'd1, 32'd1, 5'd4);
      i_clear = 1'b1;
      tick();
      i_op_stb = 1'b0;
      i_clear = 1'b0;
      check("clear_idle_block", o_op_busy, 0);
      check("clear_idle_no_wr", o_div_wr, 0);

      // Flush while the divide is in flight
      wait_idle();
      lat = 6;
      v0 = valid_count;
      drive_op(1'b0, 32'd50, 32'd5, 5'd7);
      tick();
      i_op_stb = 1'b0;
      check("flush_wr", o_div_wr, 1);
      tick();
      tick();
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      saw_wb = 1'b0;
      n = 0;
      while (o_op_busy && n < 40) begin
         if (o_wb_valid) saw_wb = 1'b1;
         tick();
         n++;
      end
      check("flush_no_wb", saw_wb, 0);
      check("flush_busy_until_valid", valid_count - v0, 1);
      check("flush_idle", o_op_busy, 0);
      lat = 3;

      // Back-to-back: second op held through RESULT, accepted after ack
      wait_idle();
      w0 = wr_count;
      drive_op(1'b0, 32'd60, 32'd4, 5'd5);
      sb.push_back('{5'd5, 32'd15, 4'h0, 1'b0});
      tick();
      drive_op(1'b0, 32'd81, 32'd9, 5'd6);
      i_op_stb = 1'b0;
      n = 0;
      while (!o_wb_valid && n < 100) begin
         tick();
         n++;
      end
      i_op_stb = 1'b1;
      tick();
      check("b2b_busy_in_result", o_op_busy, 1);
      check("b2b_wb_held", o_wb_valid, 1);
      finish_op(0);
      check("b2b_not_accepted_at_ack", o_op_busy, 0);
      check("b2b_no_wr_at_ack", o_div_wr, 0);
      sb.push_back('{5'd6, 32'd9, 4'h0, 1'b0});
      tick();
      i_op_stb = 1'b0;
      check("b2b_second_wr", o_div_wr, 1);
      finish_op(0);
      check("b2b_wr_pulses", wr_count - w0, 2);

      // Reset during BUSY
      wait_idle();
      drive_op(1'b0, 32'd9, 32'd3, 5'd8);
      tick();
      i_op_stb = 1'b0;
      tick();
      tick();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      check("mid_rst_busy", o_op_busy, 0);
      check("mid_rst_wb_valid", o_wb_valid, 0);
      check("mid_rst_div_wr", o_div_wr, 0);
      check("mid_rst_wb_reg", o_wb_reg, 0);
      check("mid_rst_div_den", o_div_den, 0);
      w0 = wr_count;
      tick();
      check("mid_rst_no_wr_after", o_div_wr, 0);
      tick();
      check("mid_rst_wr_count", wr_count - w0, 0);

      // Post-reset sanity op
      run_vec(vecs[0]);

`ifdef DIVSEQ_TIMEOUT_EN
      // Watchdog: divider never answers
      wait_idle();
      hang = 1'b1;
      drive_op(1'b0, 32'd7, 32'd1, 5'd2);
      sb.push_back('{5'd2, 32'd0, 4'h0, 1'b1});
      tick();
      i_op_stb = 1'b0;
      n = 0;
      while (!o_wb_valid && n < 100) begin
         tick();
         n++;
      end
      check("timeout_latency", n, TO + 1);
      hang = 1'b0;
      inj_valid = 1'b1;
      tick();
      inj_valid = 1'b0;
      check("late_valid_ignored_v", o_wb_valid, 1);
      check("late_valid_ignored_d", o_wb_data, 0);
      finish_op(0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
